// File: rtl/rvvi_tx_arbiter_if.sv
// rtl/rvvi_tx_arbiter_if.sv - framed 32-bit write-word channel (source side and MAC side)
interface rvvi_tx_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
);
    logic [DATA_WIDTH-1:0] Wdata;
    logic [STRB_WIDTH-1:0] Wstrb;
    logic                  Wlast;
    logic                  Wvalid;
    logic                  Wready;

    modport master (output Wdata, output Wstrb, output Wlast, output Wvalid, input Wready);
    modport slave  (input Wdata, input Wstrb, input Wlast, input Wvalid, output Wready);
endinterface

// File: rtl/rvvi_tx_arbiter.sv
// rtl/rvvi_tx_arbiter.sv - frame-atomic two-source arbiter onto the MAC write-data channel
// Optional inter-frame gap state and counter are compiled in with RVVI_ARB_GAP_EN.
module rvvi_tx_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    rvvi_tx_arbiter_if.slave      s0,
    rvvi_tx_arbiter_if.slave      s1,
    rvvi_tx_arbiter_if.master     mw,
    input  logic                  HiPri,
    input  logic [31:0]           InterFrameGap,
    output logic [1:0]            Grant,
    output logic                  Busy,
    output logic [CNT_WIDTH-1:0]  FrameCount0,
    output logic [CNT_WIDTH-1:0]  FrameCount1
);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

`ifdef RVVI_ARB_GAP_EN
    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1, GAP} state_t;
`else
    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;
`endif

    state_t state;
    state_t nextState;
    state_t postFrame;
    logic   lastGrant;
    logic   frameEnd;

    assign frameEnd = mw.Wvalid & mw.Wready & mw.Wlast;

`ifdef RVVI_ARB_GAP_EN
    logic [31:0] gapCount;
    logic        gapDone;

    // Inclusive compare so a gap lowered below the running count ends at once.
    assign gapDone   = ({1'b0, gapCount} + 33'd1) >= {1'b0, InterFrameGap};
    assign postFrame = (InterFrameGap != 32'd0) ? GAP : IDLE;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gapCount <= 32'd0;
        end else if (state == GAP) begin
            gapCount <= gapCount + 32'd1;
        end else begin
            gapCount <= 32'd0;
        end
    end
`else
    logic unusedIfg;

    assign unusedIfg = ^InterFrameGap;
    assign postFrame = IDLE;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // lastGrant=1 means source 1 won last, so source 0 takes the next tie.
    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (s1.Wvalid && (HiPri || !s0.Wvalid || !lastGrant)) begin
                    nextState = GRANT1;
                end else if (s0.Wvalid) begin
                    nextState = GRANT0;
                end
            end
            GRANT0, GRANT1: begin
                if (frameEnd) begin
                    nextState = postFrame;
                end
            end
`ifdef RVVI_ARB_GAP_EN
            GAP: begin
                if (gapDone) begin
                    nextState = IDLE;
                end
            end
`endif
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        mw.Wdata  = {DATA_WIDTH{1'b0}};
        mw.Wstrb  = {STRB_WIDTH{1'b0}};
        mw.Wlast  = 1'b0;
        mw.Wvalid = 1'b0;
        s0.Wready = 1'b0;
        s1.Wready = 1'b0;
        Grant     = 2'b00;
        Busy      = (state != IDLE);
        case (state)
            GRANT0: begin
                mw.Wdata  = s0.Wdata;
                mw.Wstrb  = s0.Wstrb;
                mw.Wlast  = s0.Wlast;
                mw.Wvalid = s0.Wvalid;
                s0.Wready = mw.Wready;
                Grant     = 2'b01;
            end
            GRANT1: begin
                mw.Wdata  = s1.Wdata;
                mw.Wstrb  = s1.Wstrb;
                mw.Wlast  = s1.Wlast;
                mw.Wvalid = s1.Wvalid;
                s1.Wready = mw.Wready;
                Grant     = 2'b10;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lastGrant   <= 1'b1;
            FrameCount0 <= {CNT_WIDTH{1'b0}};
            FrameCount1 <= {CNT_WIDTH{1'b0}};
        end else begin
            if (state == IDLE && nextState == GRANT0) begin
                lastGrant <= 1'b0;
            end else if (state == IDLE && nextState == GRANT1) begin
                lastGrant <= 1'b1;
            end
            if (state == GRANT0 && frameEnd) begin
                FrameCount0 <= FrameCount0 + CNT_ONE;
            end
            if (state == GRANT1 && frameEnd) begin
                FrameCount1 <= FrameCount1 + CNT_ONE;
            end
        end
    end
endmodule

// File: tb/tb_rvvi_tx_arbiter.sv
// tb/tb_rvvi_tx_arbiter.sv - self-checking bench for rvvi_tx_arbiter
module tb_rvvi_tx_arbiter;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int CW = 16;
`ifdef RVVI_ARB_GAP_EN
    localparam bit GAP_ON = 1'b1;
`else
    localparam bit GAP_ON = 1'b0;
`endif

    typedef logic [DW+SW:0] word_t;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          HiPri;
    logic [31:0]   InterFrameGap;
    logic [1:0]    Grant;
    logic          Busy;
    logic [CW-1:0] FrameCount0;
    logic [CW-1:0] FrameCount1;

    rvvi_tx_arbiter_if #(.DATA_WIDTH(DW), .STRB_WIDTH(SW)) s0If ();
    rvvi_tx_arbiter_if #(.DATA_WIDTH(DW), .STRB_WIDTH(SW)) s1If ();
    rvvi_tx_arbiter_if #(.DATA_WIDTH(DW), .STRB_WIDTH(SW)) mIf ();

    rvvi_tx_arbiter #(.DATA_WIDTH(DW), .STRB_WIDTH(SW), .CNT_WIDTH(CW)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .s0           (s0If),
        .s1           (s1If),
        .mw           (mIf),
        .HiPri        (HiPri),
        .InterFrameGap(InterFrameGap),
        .Grant        (Grant),
        .Busy         (Busy),
        .FrameCount0  (FrameCount0),
        .FrameCount1  (FrameCount1)
    );

    always #5 clk = ~clk;

    word_t       q0[$];
    word_t       q1[$];
    bit          readyPat[$];
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    bit          hs0 = 1'b0;
    bit          hs1 = 1'b0;
    int          mOwner = -1;
    int          mCool = 0;
    int          mLast = 1;
    int          mCnt0 = 0;
    int          mCnt1 = 0;
    int          beatCyc[$];
    int          beatGrant[$];
    bit          beatLast[$];
    logic [31:0] beatData[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Source and MAC-ready drivers: present the head of each frame queue.
    always @(posedge clk) begin : drv
        word_t w;
        #1;
        if (hs0 && q0.size() > 0) q0.delete(0);
        if (hs1 && q1.size() > 0) q1.delete(0);
        if (readyPat.size() > 0) mIf.Wready = readyPat.pop_front();
        else mIf.Wready = 1'b1;
        if (q0.size() > 0) begin
            w = q0[0];
            s0If.Wvalid = 1'b1; s0If.Wlast = w[DW+SW]; s0If.Wstrb = w[DW+SW-1:DW]; s0If.Wdata = w[DW-1:0];
        end else begin
            s0If.Wvalid = 1'b0; s0If.Wlast = 1'b0; s0If.Wstrb = '0; s0If.Wdata = '0;
        end
        if (q1.size() > 0) begin
            w = q1[0];
            s1If.Wvalid = 1'b1; s1If.Wlast = w[DW+SW]; s1If.Wstrb = w[DW+SW-1:DW]; s1If.Wdata = w[DW-1:0];
        end else begin
            s1If.Wvalid = 1'b0; s1If.Wlast = 1'b0; s1If.Wstrb = '0; s1If.Wdata = '0;
        end
    end

    // Frame-level model: an owner that keeps the channel until its last beat, then a quiet period.
    always @(negedge clk) begin : cmp
        logic          expV, expL, expR0, expR1;
        logic [DW-1:0] expD;
        logic [SW-1:0] expS;
        logic [1:0]    expG;
        logic          v0, v1;
        if (!reset_n) begin
            mOwner = -1; mCool = 0; mLast = 1; mCnt0 = 0; mCnt1 = 0; hs0 = 1'b0; hs1 = 1'b0;
        end else begin
            v0 = s0If.Wvalid; v1 = s1If.Wvalid;
            expV = 1'b0; expL = 1'b0; expR0 = 1'b0; expR1 = 1'b0; expD = '0; expS = '0; expG = 2'b00;
            if (mOwner == 0) begin
                expG = 2'b01; expV = v0; expL = s0If.Wlast; expD = s0If.Wdata; expS = s0If.Wstrb; expR0 = mIf.Wready;
            end else if (mOwner == 1) begin
                expG = 2'b10; expV = v1; expL = s1If.Wlast; expD = s1If.Wdata; expS = s1If.Wstrb; expR1 = mIf.Wready;
            end
            check("grant", 64'(Grant), 64'(expG));
            check("busy", 64'(Busy), 64'(mOwner >= 0 || mCool > 0));
            check("mwvalid", 64'(mIf.Wvalid), 64'(expV));
            check("mwlast", 64'(mIf.Wlast), 64'(expL));
            check("mwdata", 64'(mIf.Wdata), 64'(expD));
            check("mwstrb", 64'(mIf.Wstrb), 64'(expS));
            check("s0ready", 64'(s0If.Wready), 64'(expR0));
            check("s1ready", 64'(s1If.Wready), 64'(expR1));
            check("count0", 64'(FrameCount0), 64'(mCnt0));
            check("count1", 64'(FrameCount1), 64'(mCnt1));
            if (mIf.Wvalid && mIf.Wready) begin
                beatCyc.push_back(cyc); beatGrant.push_back(int'(Grant));
                beatLast.push_back(mIf.Wlast); beatData.push_back(mIf.Wdata);
            end
            hs0 = s0If.Wvalid & s0If.Wready;
            hs1 = s1If.Wvalid & s1If.Wready;
            if (mOwner >= 0) begin
                if (expV && mIf.Wready && expL) begin
                    if (mOwner == 0) mCnt0 = (mCnt0 + 1) % (1 << CW);
                    else mCnt1 = (mCnt1 + 1) % (1 << CW);
                    mOwner = -1;
                    mCool = GAP_ON ? int'(InterFrameGap) : 0;
                end
            end else if (mCool > 0) begin
                mCool--;
            end else if (v0 || v1) begin
                if (HiPri && v1) mOwner = 1;
                else if (v0 && v1) mOwner = 1 - mLast;
                else mOwner = v1 ? 1 : 0;
                mLast = mOwner;
            end
        end
    end

    task automatic sync();
        @(negedge clk);
        #1;
    endtask

    task automatic clearLogs();
        beatCyc.delete(); beatGrant.delete(); beatLast.delete(); beatData.delete();
    endtask

    task automatic pushFrame(input int src, input int n, input logic [31:0] base);
        word_t w;
        for (int i = 0; i < n; i++) begin
            w = {(i == n - 1), SW'(i + 1), base + 32'(i)};
            if (src == 0) q0.push_back(w);
            else q1.push_back(w);
        end
    endtask

    task automatic waitDone(input string name, input int limit);
        int n;
        n = 0;
        while (!(q0.size() == 0 && q1.size() == 0 && !Busy) && n < limit) begin
            @(negedge clk);
            #1;
            n++;
        end
        check(name, 64'(n < limit), 64'd1);
    endtask

    task automatic waitBeats(input string name, input int cnt, input int limit);
        int n;
        n = 0;
        while (beatCyc.size() < cnt && n < limit) begin
            @(negedge clk);
            #1;
            n++;
        end
        check(name, 64'(n < limit), 64'd1);
    endtask

    initial begin
        int pc;
        int lastG[$];
        logic [31:0] altData [8];
        reset_n = 1'b0; HiPri = 1'b0; InterFrameGap = 32'd0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_grant", 64'(Grant), 64'd0);
        check("rst_busy", 64'(Busy), 64'd0);
        check("rst_valid", 64'(mIf.Wvalid), 64'd0);
        check("rst_last", 64'(mIf.Wlast), 64'd0);
        check("rst_data", 64'(mIf.Wdata), 64'd0);
        check("rst_rdy0", 64'(s0If.Wready), 64'd0);
        check("rst_rdy1", 64'(s1If.Wready), 64'd0);
        check("rst_cnt0", 64'(FrameCount0), 64'd0);
        check("rst_cnt1", 64'(FrameCount1), 64'd0);
        #2 reset_n = 1'b1;

        // Round-robin with both sources always valid: 01,10,01,10.
        sync(); clearLogs();
        pushFrame(0, 2, 32'hA000); pushFrame(0, 2, 32'hA010);
        pushFrame(1, 2, 32'hB000); pushFrame(1, 2, 32'hB010);
        waitDone("rr_drain", 100);
        lastG.delete();
        foreach (beatLast[i]) if (beatLast[i]) lastG.push_back(beatGrant[i]);
        check("rr_frames", 64'(lastG.size()), 64'd4);
        if (lastG.size() == 4) begin
            check("rr_g0", 64'(lastG[0]), 64'd1); check("rr_g1", 64'(lastG[1]), 64'd2);
            check("rr_g2", 64'(lastG[2]), 64'd1); check("rr_g3", 64'(lastG[3]), 64'd2);
        end
        altData = '{32'hA000, 32'hA001, 32'hB000, 32'hB001, 32'hA010, 32'hA011, 32'hB010, 32'hB011};
        check("rr_beats", 64'(beatData.size()), 64'd8);
        if (beatData.size() == 8) foreach (altData[i]) check("rr_data", 64'(beatData[i]), 64'(altData[i]));
        check("rr_cnt0", 64'(FrameCount0), 64'd2);
        check("rr_cnt1", 64'(FrameCount1), 64'd2);

        // Single 3-word frame: grant one cycle after valid, three back-to-back beats.
        sync(); clearLogs(); pc = cyc;
        pushFrame(0, 3, 32'hC000);
        waitDone("f3_drain", 50);
        check("f3_beats", 64'(beatCyc.size()), 64'd3);
        if (beatCyc.size() == 3) begin
            check("f3_cyc0", 64'(beatCyc[0]), 64'(pc + 2));
            check("f3_cyc1", 64'(beatCyc[1]), 64'(pc + 3));
            check("f3_cyc2", 64'(beatCyc[2]), 64'(pc + 4));
            check("f3_grant", 64'(beatGrant[2]), 64'd1);
            check("f3_lastpos", 64'({beatLast[0], beatLast[1], beatLast[2]}), 64'b001);
        end
        check("f3_cnt0", 64'(FrameCount0), 64'd3);

        // Strict priority: source 1 wins every arbitration while it has frames.
        HiPri = 1'b1;
        sync(); clearLogs();
        pushFrame(0, 1, 32'hD000); pushFrame(1, 1, 32'hE000); pushFrame(1, 1, 32'hE010);
        waitDone("hp_drain", 50);
        check("hp_beats", 64'(beatGrant.size()), 64'd3);
        if (beatGrant.size() == 3) begin
            check("hp_g0", 64'(beatGrant[0]), 64'd2); check("hp_g1", 64'(beatGrant[1]), 64'd2);
            check("hp_g2", 64'(beatGrant[2]), 64'd1);
        end

        // Source 1 raised mid-frame: no preemption of the source-0 frame.
        sync(); clearLogs();
        pushFrame(0, 4, 32'hF000);
        waitBeats("np_start", 1, 20);
        pushFrame(1, 1, 32'hF100);
        waitDone("np_drain", 50);
        check("np_beats", 64'(beatGrant.size()), 64'd5);
        if (beatGrant.size() == 5) begin
            check("np_g3", 64'(beatGrant[3]), 64'd1);
            check("np_g4", 64'(beatGrant[4]), 64'd2);
            check("np_span", 64'(beatCyc[3] - beatCyc[0]), 64'd3);
        end
        HiPri = 1'b0;

        // Inter-frame gap of 5 between back-to-back 1-word frames.
        InterFrameGap = 32'd5;
        sync(); clearLogs(); pc = cyc;
        pushFrame(0, 1, 32'h1111_0000); pushFrame(0, 1, 32'h1111_0001);
        waitDone("gap_drain", 50);
        check("gap_beats", 64'(beatCyc.size()), 64'd2);
        if (beatCyc.size() == 2) begin
            check("gap_first", 64'(beatCyc[0]), 64'(pc + 2));
            check("gap_space", 64'(beatCyc[1] - beatCyc[0]), GAP_ON ? 64'd7 : 64'd2);
        end
        InterFrameGap = 32'd0;

        // MWready 1,0,0,1 inside a 4-word frame (first pattern slot covers the IDLE cycle).
        sync(); clearLogs(); pc = cyc;
        readyPat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        pushFrame(0, 4, 32'h5EED_0000);
        waitDone("st_drain", 50);
        check("st_beats", 64'(beatData.size()), 64'd4);
        if (beatData.size() == 4) begin
            foreach (beatData[i]) check("st_data", 64'(beatData[i]), 64'(32'h5EED_0000 + 32'(i)));
            check("st_cyc0", 64'(beatCyc[0]), 64'(pc + 2));
            check("st_cyc1", 64'(beatCyc[1]), 64'(pc + 5));
            check("st_cyc3", 64'(beatCyc[3]), 64'(pc + 7));
        end

        // Reset asserted while word 2 of 4 is on the bus.
        sync(); clearLogs();
        pushFrame(0, 4, 32'h7000);
        waitBeats("rs_start", 1, 20);
        @(posedge clk);
        #3;
        check("rs_word2", 64'(mIf.Wdata), 64'h7001);
        reset_n = 1'b0;
        #1;
        check("rs_valid", 64'(mIf.Wvalid), 64'd0);
        check("rs_grant", 64'(Grant), 64'd0);
        check("rs_busy", 64'(Busy), 64'd0);
        check("rs_cnt0", 64'(FrameCount0), 64'd0);
        check("rs_cnt1", 64'(FrameCount1), 64'd0);
        q0.delete(); q1.delete(); readyPat.delete();
        @(negedge clk);
        @(posedge clk);
        #3 reset_n = 1'b1;
        sync(); clearLogs(); pc = cyc;
        pushFrame(1, 1, 32'h8000);
        waitDone("rs_drain", 50);
        check("rs_nbeats", 64'(beatCyc.size()), 64'd1);
        if (beatCyc.size() == 1) begin
            check("rs_ngrant", 64'(beatGrant[0]), 64'd2);
            check("rs_ncyc", 64'(beatCyc[0]), 64'(pc + 2));
        end
        check("rs_ncnt1", 64'(FrameCount1), 64'd1);

        sync();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rvvi_tx_arbiter.md
# rvvi_tx_arbiter

Frame-atomic arbiter that shares the single 32-bit Ethernet MAC write-data channel between two framed word sources. Source 0 is the RVVI packetizer stream; source 1 is the host-control/ack frame generator. The arbiter never interleaves words from different frames. It can enforce a programmable inter-frame gap, and it counts the frames forwarded from each source. It sits between the packetizer and the MAC transmit FIFO.

## Interface
Parameters:
- `DATA_WIDTH`, default 32: word width of all data buses.
- `STRB_WIDTH`, default 4: strobe width; equals `DATA_WIDTH`/8.
- `CNT_WIDTH`, default 16: width of each per-source frame counter.

Ports:
- `clk`  in  1: the single clock; all state changes on the rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `S0Wdata`/`S1Wdata`  in  `DATA_WIDTH`: source write data.
- `S0Wstrb`/`S1Wstrb`  in  `STRB_WIDTH`: source byte strobes.
- `S0Wlast`/`S1Wlast`  in  1: marks the final word of a source frame.
- `S0Wvalid`/`S1Wvalid`  in  1: source word valid.
- `S0Wready`/`S1Wready`  out  1: source word accepted.
- `MWdata`  out  `DATA_WIDTH`: data to the MAC.
- `MWstrb`  out  `STRB_WIDTH`: strobes to the MAC.
- `MWlast`  out  1: last word of the frame to the MAC.
- `MWvalid`  out  1: word valid to the MAC.
- `MWready`  in  1: MAC accepts the word.
- `HiPri`  in  1: 1 gives source 1 strict priority over source 0.
- `InterFrameGap`  in  32: number of idle cycles forced after each frame.
- `Grant`  out  2: one-hot owner of the channel; 0 when no source owns it.
- `Busy`  out  1: high in any state other than IDLE.
- `FrameCount0`/`FrameCount1`  out  `CNT_WIDTH`: frames forwarded per source.

## Operation
States: IDLE, GRANT0, GRANT1, GAP.

IDLE:
- If any `SxWvalid` is high, pick a winner and go to GRANTx.
- When `HiPri`=1 and `S1Wvalid`=1, source 1 wins.
- Otherwise use round-robin on the registered `LastGrant`. `LastGrant` resets to 1, so source 0 wins the first tie.
- `LastGrant` updates on entry to GRANTx.

GRANTx:
- Pass-through is purely combinational: `MWdata`/`MWstrb`/`MWlast`/`MWvalid` = source x fields, and `SxWready` = `MWready`.
- The non-granted source sees `Wready`=0.
- A handshake is `MWvalid & MWready`.
- On a handshake with `MWlast`=1:
  - `FrameCountx` increments; it wraps modulo 2^`CNT_WIDTH`.
  - Next state is GAP if `InterFrameGap`≠0, otherwise IDLE.
- `HiPri` and the other source's valid are ignored until the frame ends. Frames are never preempted.

GAP:
- A 32-bit counter clears on entry and increments each cycle.
- Leave to IDLE when count == `InterFrameGap`−1.
- `InterFrameGap` is sampled on every cycle. Lowering it below the current count exits on the next cycle.

Outputs outside GRANTx:
- `MWvalid`=0, both `SxWready`=0, `MWlast`=0, `MWdata`/`MWstrb`=0.

Reset asserted mid-frame:
- All state clears immediately. `MWvalid` drops without `MWlast`.
- The MAC side must discard the truncated frame. The sources are reset by the same `reset_n`.

## Timing
- Reset values: state=IDLE, `Grant`=0, `Busy`=0, `MWvalid`=0, `MWlast`=0, `MWdata`=0, `MWstrb`=0, `S0Wready`=`S1Wready`=0, `FrameCount0`=`FrameCount1`=0, `LastGrant`=1, gap counter=0.
- Arbitration latency is 1 cycle. Valid seen in IDLE at cycle t gives `Grant` and a possible first handshake at t+1.
- Gap timing: last beat at cycle t, GAP occupies t+1..t+N (N=`InterFrameGap`), IDLE at t+N+1, earliest next first beat at t+N+2.
- With N=0 the earliest next first beat is t+2.
- Throughput inside a frame is 1 word/cycle when `MWready` is held high.
- `MWready` low stalls in place with zero added latency.

## Configuration
- `RVVI_ARB_GAP_EN` defined:
  - GAP state, the 32-bit gap counter and the `InterFrameGap` behaviour are compiled in as described above.
- Not defined:
  - GAP state and counter are removed. After `MWlast` the arbiter always returns to IDLE.
  - The `InterFrameGap` port remains but is ignored.
  - Back-to-back frames are spaced by exactly one IDLE cycle.

## Test plan
- Reset, then `S0Wvalid`=1 with a 3-word frame (`MWready`=1) -> `Grant`=01 one cycle later; 3 beats on consecutive cycles with `MWlast` on the 3rd; `FrameCount0`=1.
- Both sources valid continuously, `HiPri`=0, 2-word frames, `InterFrameGap`=0 -> grants alternate 01,10,01,10; after 4 frames `FrameCount0`=`FrameCount1`=2.
- `HiPri`=1, both valid -> source 1 wins every arbitration. Raise `S1Wvalid` mid-way through a source-0 frame -> source-0 frame completes uninterrupted, then source 1 is granted.
- `InterFrameGap`=5, source 0 sends back-to-back 1-word frames -> exactly 5 GAP cycles with `MWvalid`=0; next beat 7 cycles after the previous last beat; with `RVVI_ARB_GAP_EN` undefined the next beat comes 2 cycles after.
- `MWready` toggled 1,0,0,1 during a 4-word frame -> `MWdata` holds its value while stalled; `S0Wready` mirrors `MWready`; no words are lost or duplicated.
- `reset_n` asserted mid-frame on word 2 of 4 -> `MWvalid`, `Grant` and the counters are 0 immediately, asynchronously to `clk`; after release, a new frame arbitrates normally.
